// File: rtl/async_fifo_pkg.sv
// Shared definitions for the dual-clock FIFO write and read controllers.
// Holds the default pointer width and Gray/binary conversion helpers.
// The helpers work on a zero-extended MAX_PTR_W vector. Callers cast the
// ADDR_WIDTH+1 pointer in and truncate the result back out, so any pointer
// width up to MAX_PTR_W is supported.
package async_fifo_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 4;
    localparam int unsigned PTR_W          = ADDR_WIDTH_DEF + 1;
    localparam int unsigned MAX_PTR_W      = 32;

    typedef logic [MAX_PTR_W-1:0] ptr_max_t;

    function automatic ptr_max_t bin2gray(input ptr_max_t b);
        return b ^ (b >> 1);
    endfunction

    // Bit i of the binary value is the XOR of all Gray bits at or above i.
    // Zero upper bits leave that XOR unchanged, so a fixed-width loop is
    // correct for every narrower pointer.
    function automatic ptr_max_t gray2bin(input ptr_max_t g);
        ptr_max_t b;
        b = '0;
        for (int i = 0; i < int'(MAX_PTR_W); i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing clock domains.
// Ports:
//   clk_i  - destination clock
//   rst_ni - asynchronous active-low reset; all stages clear to 0
//   d_i    - WIDTH-bit input from the source domain
//   q_o    - output of the last of STAGES flops
module sync_ff #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < int'(STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// Write-domain controller of the dual-clock FIFO.
// Keeps a binary and a Gray write pointer, synchronises the read pointer
// into wclk, and drives registered full, almost-full, occupancy and a
// sticky overflow flag.
// Ports:
//   wclk, wrst_n - write clock, asynchronous active-low reset
//   winc         - producer write request
//   wovf_clr     - clears woverflow; a new overflow in the same cycle wins
//   rptr_gray    - Gray read pointer from the read domain
//   wen, waddr   - RAM write port enable and address
//   wptr_gray    - registered Gray write pointer for the read domain
//   wfull, walmost_full, wcount, woverflow - registered status
module async_fifo_wr_ctrl
    import async_fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned AFULL_THRESH = 2**ADDR_WIDTH - 4
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic                  winc,
    input  logic                  wovf_clr,
    input  logic [ADDR_WIDTH:0]   rptr_gray,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr_gray,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic [ADDR_WIDTH:0]   wcount,
    output logic                  woverflow
);

    localparam int unsigned PW = ADDR_WIDTH + 1;
    // Full when the write pointer is one lap ahead: the top two Gray bits
    // differ from the read pointer and the rest match.
    localparam logic [PW-1:0] FullMask = PW'(3) << (PW - 2);
    localparam logic [PW-1:0] AfullThr = PW'(AFULL_THRESH);

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wgray_q, wgray_d;
    logic [PW-1:0] wcount_q, wcount_d;
    logic          wfull_q, wfull_d;
    logic          wafull_q, wafull_d;
    logic          wovf_q, wovf_d;
    logic [PW-1:0] rq;
    logic [PW-1:0] rbin_s;

    sync_ff #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .clk_i  (wclk),
        .rst_ni (wrst_n),
        .d_i    (rptr_gray),
        .q_o    (rq)
    );

    always_comb begin
        wen      = winc & ~wfull_q;
        wbin_d   = wbin_q + PW'(wen);
        wgray_d  = PW'(bin2gray(ptr_max_t'(wbin_d)));
        rbin_s   = PW'(gray2bin(ptr_max_t'(rq)));
        wfull_d  = (wgray_d == (rq ^ FullMask));
        // Modular difference; the read pointer never passes the write pointer.
        wcount_d = wbin_d - rbin_s;
        wafull_d = (wcount_d >= AfullThr);
        wovf_d   = (winc & wfull_q) | (wovf_q & ~wovf_clr);
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_q   <= '0;
            wgray_q  <= '0;
            wcount_q <= '0;
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
            wovf_q   <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wgray_q  <= wgray_d;
            wcount_q <= wcount_d;
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
            wovf_q   <= wovf_d;
        end
    end

    assign waddr        = wbin_q[ADDR_WIDTH-1:0];
    assign wptr_gray    = wgray_q;
    assign wfull        = wfull_q;
    assign walmost_full = wafull_q;
    assign wcount       = wcount_q;
    assign woverflow    = wovf_q;

endmodule
